uart_frame_loader: RTL and testbench

- Wishbone master that fills the 8x8 RGB matrix frame buffer from a UART byte stream (FTDI serial, 8N1).
- Sits directly upstream of the matrix wishbone slave, in place of or muxed with the on-board pattern master.
- Receives a sync byte, then 32 pixel bytes. Packs them into eight 32-bit words and issues one pipelined wishbone write per row.

---
 rtl/matrix_pkg.sv | 50 +++++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/uart_frame_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, FSM state types and a lane-packing
// helper for the RGB matrix frame-buffer wishbone masters.
// Defining UART_FRAME_LOADER_CHECKSUM_EN adds the F_CHECK frame state.
package matrix_pkg;

    localparam int MATRIX_ROWS   = 8;
    localparam int MATRIX_ADDR_W = 3;
    localparam int WB_DATA_W     = 32;
    localparam int WB_SEL_W      = 4;
    localparam int FRAME_BYTES   = MATRIX_ROWS * WB_SEL_W;

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_CHECK
    } frame_state_t;
`else
    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA
    } frame_state_t;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT
    } wb_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    // Replace byte lane `lane` of `word` (lane 0 = bits 7:0).
    function automatic logic [WB_DATA_W-1:0] put_lane(
        input logic [WB_DATA_W-1:0] word,
        input logic [1:0]           lane,
        input logic [7:0]           b
    );
        logic [WB_DATA_W-1:0] w;
        w = word;
        w[lane*8 +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer.
// Ports: clk, reset (sync, active-high), i_rx (async, idle high),
//        o_data (received byte), o_valid (1-cycle, good stop bit),
//        o_frame_err (1-cycle, stop bit read low; byte dropped).
module uart_rx
    import matrix_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= R_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= R_START;
                    end
                end
                R_START: begin
                    // Mid start bit: a high line means a glitch.
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= R_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        if (rx_sync) begin
                            o_data  <= shift;
                            o_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: UART (8N1) to wishbone master that loads the 8x8
// RGB frame buffer; sync byte + 32 pixel bytes -> 8 row writes.
// Ports: clk, reset (sync, active-high), i_rx (UART line),
//        o_wb_cyc/stb/we/addr/sel/wdata, i_wb_ack/stall/rdata (wishbone
//        master), o_frame_done (row 7 acked on a clean frame), o_err.
// Macro UART_FRAME_LOADER_CHECKSUM_EN: extra XOR checksum byte per frame.
module uart_frame_loader
    import matrix_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 250000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_rx,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [MATRIX_ADDR_W-1:0] o_wb_addr,
    output logic [WB_SEL_W-1:0]      o_wb_sel,
    output logic [WB_DATA_W-1:0]     o_wb_wdata,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic [WB_DATA_W-1:0]     i_wb_rdata,
    output logic                     o_frame_done,
    output logic                     o_err
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CLKS - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .i_rx       (i_rx),
        .o_data     (rx_data),
        .o_valid    (rx_valid),
        .o_frame_err(rx_ferr)
    );

    frame_state_t             f_state;
    wb_state_t                w_state;
    logic [4:0]               byte_cnt;
    logic [WB_DATA_W-1:0]     word_buf;
    logic [WB_DATA_W-1:0]     hold_data;
    logic [MATRIX_ADDR_W-1:0] hold_addr;
    logic                     wr_req;
    logic                     row7_wr;
    logic [TO_W-1:0]          to_cnt;
    logic [WB_DATA_W-1:0]     next_word;
    logic                     timeout;
    logic                     wb_busy;
    logic                     wb_acked;
    logic                     row7_ack_now;
    logic                     unused_rdata;

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    logic [7:0] ck_acc;
    logic       ck_ok;
    logic       row7_acked;
`endif

    assign unused_rdata = ^i_wb_rdata;
    assign o_wb_sel     = '1;

    assign next_word = put_lane(word_buf, byte_cnt[1:0], rx_data);
    assign timeout   = (f_state != F_IDLE) && (to_cnt == TO_MAX);
    assign wb_busy   = (w_state != W_IDLE) || wr_req;

    // Ack may land together with acceptance (W_REQ, no stall).
    assign wb_acked = i_wb_ack &&
                      ((w_state == W_WAIT) ||
                       (w_state == W_REQ && !i_wb_stall));
    assign row7_ack_now = wb_acked && row7_wr &&
                          (o_wb_addr == MATRIX_ADDR_W'(MATRIX_ROWS - 1));

    // Frame assembly FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            f_state      <= F_IDLE;
            byte_cnt     <= '0;
            word_buf     <= '0;
            hold_data    <= '0;
            hold_addr    <= '0;
            wr_req       <= 1'b0;
            row7_wr      <= 1'b0;
            to_cnt       <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            ck_acc       <= '0;
            ck_ok        <= 1'b0;
            row7_acked   <= 1'b0;
`endif
        end else begin
            wr_req       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= rx_ferr;

            if (f_state == F_IDLE || rx_valid) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (row7_ack_now) begin
                row7_wr <= 1'b0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                if (ck_ok) begin
                    o_frame_done <= 1'b1;
                    ck_ok        <= 1'b0;
                end else begin
                    row7_acked <= 1'b1;
                end
`else
                o_frame_done <= 1'b1;
`endif
            end

            unique case (f_state)
                F_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        byte_cnt <= '0;
                        f_state  <= F_DATA;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                        ck_acc     <= '0;
                        ck_ok      <= 1'b0;
                        row7_acked <= 1'b0;
                        row7_wr    <= 1'b0;
`endif
                    end
                end
                F_DATA: begin
                    if (rx_valid) begin
                        word_buf <= next_word;
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                        ck_acc <= ck_acc ^ rx_data;
`endif
                        if (byte_cnt[1:0] == 2'd3) begin
                            if (wb_busy) begin
                                // Overrun: drop word, abort frame.
                                o_err   <= 1'b1;
                                f_state <= F_IDLE;
                            end else begin
                                hold_data <= next_word;
                                hold_addr <= byte_cnt[4:2];
                                wr_req    <= 1'b1;
                                if (byte_cnt == 5'd31) begin
                                    row7_wr <= 1'b1;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                                    f_state <= F_CHECK;
`else
                                    f_state <= F_IDLE;
`endif
                                end
                            end
                        end
                    end else if (rx_ferr || timeout) begin
                        o_err   <= 1'b1;
                        f_state <= F_IDLE;
                    end
                end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                F_CHECK: begin
                    if (rx_valid) begin
                        f_state <= F_IDLE;
                        if (rx_data == ck_acc) begin
                            if (row7_acked || row7_ack_now) begin
                                o_frame_done <= 1'b1;
                                row7_acked   <= 1'b0;
                            end else begin
                                ck_ok <= 1'b1;
                            end
                        end else begin
                            o_err <= 1'b1;
                        end
                    end else if (rx_ferr || timeout) begin
                        o_err   <= 1'b1;
                        f_state <= F_IDLE;
                    end
                end
`endif
                default: f_state <= F_IDLE;
            endcase
        end
    end

    // Wishbone pipelined single-write FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_wdata <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (wr_req) begin
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                        o_wb_we    <= 1'b1;
                        o_wb_addr  <= hold_addr;
                        o_wb_wdata <= hold_data;
                        w_state    <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        if (i_wb_ack) begin
                            o_wb_cyc <= 1'b0;
                            o_wb_we  <= 1'b0;
                            w_state  <= W_IDLE;
                        end else begin
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_we  <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: randomized UART frames against a frame-level
// reference model; wishbone slave with programmable stall/ack latency.
module tb_uart_frame_loader;

    localparam int         CPB  = 8;
    localparam int         TO   = 600;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rx;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_rdata;
    logic        o_frame_done;
    logic        o_err;

    always #5 clk = ~clk;

    uart_frame_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_addr   (o_wb_addr),
        .o_wb_sel    (o_wb_sel),
        .o_wb_wdata  (o_wb_wdata),
        .i_wb_ack    (i_wb_ack),
        .i_wb_stall  (i_wb_stall),
        .i_wb_rdata  (i_wb_rdata),
        .o_frame_done(o_frame_done),
        .o_err       (o_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [34:0] wr_q[$];
    logic [34:0] exp_q[$];
    logic [7:0]  frame[32];
    int          cfg_stall = 0;
    int          cfg_ack   = 1;
    int          done_cnt  = 0;
    int          err_cnt   = 0;

    // Wishbone slave: decisions made on the falling edge for the next rise.
    initial begin : slave
        int          stall_left;
        int          ack_left;
        bit          pend;
        logic [34:0] held;
        stall_left = -1;
        ack_left   = 0;
        pend       = 0;
        held       = '0;
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_rdata = '0;
        forever begin
            @(negedge clk);
            i_wb_ack = 1'b0;
            if (reset || !o_wb_cyc) begin
                i_wb_stall = 1'b0;
                stall_left = -1;
                pend       = 0;
            end else if (o_wb_stb) begin
                if (stall_left < 0) begin
                    stall_left = cfg_stall;
                    held       = {o_wb_addr, o_wb_wdata};
                end else begin
                    check("stall_hold", 64'({o_wb_addr, o_wb_wdata}),
                          64'(held));
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    i_wb_stall = 1'b0;
                    stall_left = -2;
                    wr_q.push_back({o_wb_addr, o_wb_wdata});
                    check("wb_sel", 64'(o_wb_sel), 64'hF);
                    check("wb_we", 64'(o_wb_we), 64'h1);
                    if (cfg_ack == 0) begin
                        i_wb_ack = 1'b1;
                    end else begin
                        pend     = 1;
                        ack_left = cfg_ack;
                    end
                end
            end else if (pend) begin
                ack_left--;
                if (ack_left == 0) begin
                    i_wb_ack = 1'b1;
                    pend     = 0;
                end
            end
        end
    end

    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (!reset && o_frame_done) done_cnt++;
            if (!reset && o_err) err_cnt++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, bit stop_ok);
        i_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            tick(CPB);
        end
        i_rx = stop_ok;
        tick(CPB);
        i_rx = 1'b1;
        tick(stop_ok ? int'($urandom_range(0, 12)) : 2 * CPB);
    endtask

    // Send garbage (optional), sync, n_send bytes; bad_idx gets stop=0.
    task automatic run_frame(string nm, int n_garb, int bad_idx,
                             int n_send, bit ck_good);
        logic [7:0] garb[3];
        logic [7:0] ck;
        int         d0;
        int         e0;
        int         n_good;
        bit         complete;
        int         exp_done;
        int         exp_err;
        garb[0] = 8'h00;
        garb[1] = 8'hFF;
        garb[2] = 8'h12;
        d0 = done_cnt;
        e0 = err_cnt;
        wr_q.delete();
        exp_q.delete();
        for (int i = 0; i < n_garb; i++) send_byte(garb[i], 1'b1);
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < n_send; i++) begin
            send_byte(frame[i], i != bad_idx);
            if (i == bad_idx) break;
        end
        complete = (bad_idx < 0) && (n_send == 32);
        ck = 8'h00;
        for (int i = 0; i < 32; i++) ck = ck ^ frame[i];
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        if (complete) send_byte(ck_good ? ck : (ck ^ 8'h01), 1'b1);
        exp_done = (complete && ck_good) ? 1 : 0;
        exp_err  = (complete && ck_good) ? 0 : 1;
`else
        exp_done = complete ? 1 : 0;
        exp_err  = complete ? 0 : 1;
`endif
        if (!complete && bad_idx < 0) tick(TO + 100);
        else tick(80);
        n_good = (bad_idx >= 0) ? bad_idx : n_send;
        for (int r = 0; r < n_good / 4; r++) begin
            exp_q.push_back({3'(r), frame[4*r+3], frame[4*r+2],
                             frame[4*r+1], frame[4*r]});
        end
        check({nm, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s_row%0d", nm, i), 64'(wr_q[i]),
                  64'(exp_q[i]));
        end
        check({nm, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
        check({nm, "_err"}, 64'(err_cnt - e0), 64'(exp_err));
        check({nm, "_cyc_idle"}, 64'(o_wb_cyc), 64'h0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) frame[i] = 8'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) frame[i] = 8'($urandom);
    endtask

    initial begin : main
        bit seen;
        reset = 1'b1;
        i_rx  = 1'b1;
        tick(4);
        check("rst_cyc", 64'(o_wb_cyc), 64'h0);
        check("rst_stb", 64'(o_wb_stb), 64'h0);
        check("rst_we", 64'(o_wb_we), 64'h0);
        check("rst_addr", 64'(o_wb_addr), 64'h0);
        check("rst_sel", 64'(o_wb_sel), 64'hF);
        check("rst_wdata", 64'(o_wb_wdata), 64'h0);
        check("rst_done", 64'(o_frame_done), 64'h0);
        check("rst_err", 64'(o_err), 64'h0);
        reset = 1'b0;
        tick(20);

        fill_ramp();
        cfg_stall = 0;
        cfg_ack   = 1;
        run_frame("ramp", 0, -1, 32, 1'b1);
        if (wr_q.size() == 8) begin
            check("ramp_w0", 64'(wr_q[0][31:0]), 64'h03020100);
            check("ramp_w7", 64'(wr_q[7]), 64'({3'd7, 32'h1F1E1D1C}));
        end

        cfg_stall = 3;
        cfg_ack   = 5;
        run_frame("stall", 0, -1, 32, 1'b1);

        fill_rand();
        cfg_stall = int'($urandom_range(0, 3));
        cfg_ack   = int'($urandom_range(0, 5));
        run_frame("garbage", 3, -1, 32, 1'b1);

        fill_rand();
        run_frame("badstop", 0, 10, 32, 1'b1);
        fill_rand();
        run_frame("after_bad", 0, -1, 32, 1'b1);

        fill_rand();
        cfg_stall = 0;
        cfg_ack   = 1;
        run_frame("timeout", 0, -1, 12, 1'b1);
        fill_rand();
        run_frame("after_to", 0, -1, 32, 1'b1);

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
        fill_ramp();
        run_frame("ck_bad", 0, -1, 32, 1'b0);
`endif

        for (int k = 0; k < 3; k++) begin
            fill_rand();
            cfg_stall = int'($urandom_range(0, 3));
            cfg_ack   = int'($urandom_range(0, 5));
            run_frame($sformatf("rand%0d", k), 0, -1, 32, 1'b1);
        end

        // Reset while the first row write is stalled on the bus.
        fill_rand();
        cfg_stall = 5000;
        send_byte(SYNC, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (o_wb_stb) seen = 1;
            else tick(1);
        end
        check("rstmid_stb_pre", 64'(o_wb_stb), 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_cyc", 64'(o_wb_cyc), 64'h0);
        check("rstmid_stb", 64'(o_wb_stb), 64'h0);
        tick(2);
        reset     = 1'b0;
        cfg_stall = 0;
        tick(10);
        fill_rand();
        run_frame("after_rst", 0, -1, 32, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
